// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// State encodings are exposed on the debug port.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int DEF_RST_HOLD_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 4;

  // Never returns less than 1 so a width is always legal.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the sequencer and the PLL wrapper.
// master = sequencer side, slave = PLL/consumer side.
interface pll_lock_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int MAX_RETRIES = DEF_MAX_RETRIES
) ();

  localparam int RW = clog2(MAX_RETRIES + 1);

  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          ready;
  logic          fail;
  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    loss_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, ready, fail,
    output state, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, ready, fail,
    input  state, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer with async reset.
// Reusable for any asynchronous status input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer on the reference clock.
// Hold reset, wait for lock with retries, qualify, then run.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input logic                  refclk,
  input logic                  rst,
  pll_lock_sequencer_if.master bus
);

  localparam int M1 =
    (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
    RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CMAX =
    (LOCK_TIMEOUT_CYCLES > M1) ? LOCK_TIMEOUT_CYCLES : M1;
  localparam int CW = clog2(CMAX);
  localparam int RW = clog2(MAX_RETRIES + 1);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [RW-1:0] retry_q, retry_n, retry_inc;
  logic [7:0]    loss_q, loss_n;
  logic          pll_rst_q, ready_q, fail_q;
  logic          locked_s;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    retry_n   = retry_q;
    loss_n    = loss_q;
    retry_inc = retry_q + RW'(1);
    unique case (state_q)
      HOLD: begin
        if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_n   = '0;
          retry_n = retry_inc;
          state_n = (retry_inc == RW'(MAX_RETRIES)) ? FAIL : HOLD;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = HOLD;
          cnt_n   = '0;
          if (loss_q != 8'hFF) loss_n = loss_q + 8'd1;
        end
      end
      FAIL: ;
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    endcase
    // Relock wins over everything but keeps any lock-loss count.
    if (bus.relock_req) begin
      state_n = HOLD;
      cnt_n   = '0;
      if (state_q == FAIL) retry_n = '0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      retry_q   <= retry_n;
      loss_q    <= loss_n;
      pll_rst_q <= (state_n == HOLD) || (state_n == FAIL);
      ready_q   <= (state_n == RUN);
      fail_q    <= (state_n == FAIL);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters.
// Expected values are hand-derived cycle counts.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic refclk;
  logic rst;
  int   pass_cnt;
  int   total;

  pll_lock_sequencer_if #(.MAX_RETRIES(3)) bus ();

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (3)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget && bus.ready !== 1'b1; k++)
      tick(1);
    check("wait_ready", 32'(bus.ready), 1);
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_state"}, 32'(bus.state), 0);
    check({tag, "_pll_rst"}, 32'(bus.pll_rst), 1);
    check({tag, "_ready"}, 32'(bus.ready), 0);
    check({tag, "_fail"}, 32'(bus.fail), 0);
    check({tag, "_retry"}, 32'(bus.retry_cnt), 0);
    check({tag, "_loss"}, 32'(bus.loss_cnt), 0);
  endtask

  initial begin
    pass_cnt       = 0;
    total          = 0;
    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    #1;
    check_rst_vals("rst0");

    // 1: power-up with lock at cycle 10
    tick(2);
    rst = 1'b0;
    tick(3);
    check("c1_hold_state", 32'(bus.state), 0);
    check("c1_hold_rst", 32'(bus.pll_rst), 1);
    tick(1);
    check("c1_wait_state", 32'(bus.state), 1);
    check("c1_wait_rst", 32'(bus.pll_rst), 0);
    tick(6);
    bus.pll_locked = 1'b1;
    tick(2);
    check("c1_sync_lag", 32'(bus.state), 1);
    tick(1);
    check("c1_stable", 32'(bus.state), 2);
    tick(7);
    check("c1_pre_run", 32'(bus.state), 2);
    check("c1_pre_ready", 32'(bus.ready), 0);
    tick(1);
    check("c1_run", 32'(bus.state), 3);
    check("c1_ready", 32'(bus.ready), 1);
    check("c1_retry", 32'(bus.retry_cnt), 0);

    // 2: no lock, retries exhaust
    bus.pll_locked = 1'b0;
    do_reset();
    tick(36);
    check("c2_retry1", 32'(bus.retry_cnt), 1);
    check("c2_hold1", 32'(bus.state), 0);
    check("c2_hold1_rst", 32'(bus.pll_rst), 1);
    tick(71);
    check("c2_wait3", 32'(bus.state), 1);
    check("c2_retry2", 32'(bus.retry_cnt), 2);
    check("c2_nofail", 32'(bus.fail), 0);
    tick(1);
    check("c2_fail_state", 32'(bus.state), 4);
    check("c2_fail", 32'(bus.fail), 1);
    check("c2_fail_rst", 32'(bus.pll_rst), 1);
    check("c2_retry3", 32'(bus.retry_cnt), 3);
    tick(200);
    check("c2_stay_state", 32'(bus.state), 4);
    check("c2_stay_fail", 32'(bus.fail), 1);

    // 3: relock out of FAIL
    bus.pll_locked = 1'b1;
    bus.relock_req = 1'b1;
    tick(1);
    bus.relock_req = 1'b0;
    check("c3_state", 32'(bus.state), 0);
    check("c3_fail", 32'(bus.fail), 0);
    check("c3_retry", 32'(bus.retry_cnt), 0);
    check("c3_pll_rst", 32'(bus.pll_rst), 1);
    tick(12);
    check("c3_pre_run", 32'(bus.state), 2);
    check("c3_pre_ready", 32'(bus.ready), 0);
    tick(1);
    check("c3_ready", 32'(bus.ready), 1);

    // 4: glitch during qualification
    bus.pll_locked = 1'b1;
    do_reset();
    tick(10);
    check("c4_stable5", 32'(bus.state), 2);
    bus.pll_locked = 1'b0;
    tick(2);
    check("c4_still_stable", 32'(bus.state), 2);
    check("c4_no_ready", 32'(bus.ready), 0);
    tick(1);
    check("c4_back_wait", 32'(bus.state), 1);
    check("c4_wait_ready", 32'(bus.ready), 0);
    bus.pll_locked = 1'b1;
    tick(10);
    check("c4_requal", 32'(bus.state), 2);
    check("c4_requal_rdy", 32'(bus.ready), 0);
    tick(1);
    check("c4_run", 32'(bus.state), 3);
    check("c4_ready", 32'(bus.ready), 1);

    // 5: lock loss in RUN, then saturation
    bus.pll_locked = 1'b0;
    tick(2);
    check("c5_ready_lag", 32'(bus.ready), 1);
    tick(1);
    check("c5_ready_drop", 32'(bus.ready), 0);
    check("c5_hold", 32'(bus.state), 0);
    check("c5_loss1", 32'(bus.loss_cnt), 1);
    check("c5_pll_rst", 32'(bus.pll_rst), 1);
    tick(3);
    check("c5_hold_end", 32'(bus.pll_rst), 1);
    tick(1);
    check("c5_rst_rel", 32'(bus.pll_rst), 0);
    for (int i = 2; i <= 300; i++) begin
      bus.pll_locked = 1'b1;
      wait_ready(40);
      bus.pll_locked = 1'b0;
      tick(3);
      if (i == 254)
        check("c5_loss254", 32'(bus.loss_cnt), 254);
    end
    check("c5_loss_sat", 32'(bus.loss_cnt), 255);
    check("c5_sat_ready", 32'(bus.ready), 0);

    // 6: async reset mid-STABLE and mid-RUN
    bus.pll_locked = 1'b1;
    do_reset();
    tick(7);
    check("c6_in_stable", 32'(bus.state), 2);
    #2;
    rst = 1'b1;
    #1;
    check_rst_vals("c6_stable");
    rst = 1'b0;
    wait_ready(40);
    bus.pll_locked = 1'b0;
    tick(3);
    check("c6_loss1", 32'(bus.loss_cnt), 1);
    bus.pll_locked = 1'b1;
    wait_ready(40);
    #2;
    rst = 1'b1;
    #1;
    check_rst_vals("c6_run");
    rst = 1'b0;
    wait_ready(40);
    bus.pll_locked = 1'b0;
    tick(2);
    check("c6_co_ready", 32'(bus.ready), 1);
    bus.relock_req = 1'b1;
    tick(1);
    bus.relock_req = 1'b0;
    check("c6_co_state", 32'(bus.state), 0);
    check("c6_co_loss", 32'(bus.loss_cnt), 1);
    check("c6_co_ready0", 32'(bus.ready), 0);
    tick(3);
    check("c6_co_hold", 32'(bus.state), 0);
    tick(1);
    check("c6_co_wait", 32'(bus.state), 1);
    check("c6_co_loss_k", 32'(bus.loss_cnt), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
